pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. Generates the PC-write, IF/ID-write, ID bubble (`idstall`) and IF/ID flush controls that sequence the PC register and the IF/ID latch. It handles three hazard types:
- branch/jump redirect;
- load-use data hazard;
- multi-cycle multiply/divide occupancy.

It sits between the decode stage, the ID/EX register and the PC/IF-ID registers.

## Interface
Parameters:
- `MUL_CYCLES`, default 4: multiply latency in cycles; legal range 1..2^CNT_W.
- `DIV_CYCLES`, default 16: divide latency in cycles; legal range 1..2^CNT_W.
- `CNT_W`, default 5: width of the MDU countdown counter.

Ports:
- `clk`  in  1: system clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `id_rs`  in  5: rs field of the instruction in IF/ID.
- `id_rt`  in  5: rt field of the instruction in IF/ID.
- `id_use_rt`  in  1: the ID instruction reads rt as a source.
- `ex_memread`  in  1: the ID/EX register holds a load.
- `ex_rt`  in  5: destination register of that load.
- `ex_branch_taken`  in  1: branch/jump resolved taken in EX.
- `md_start`  in  1: the ID instruction is a mult/div.
- `md_op`  in  1: 0 = mult, 1 = div.
- `id_md_dep`  in  1: the ID instruction needs the MDU (mfhi, mflo, mult, div).
- `pcwrite`  out  1: PC register load enable.
- `ifidwrite`  out  1: IF/ID load enable.
- `idstall`  out  1: insert a bubble into ID/EX.
- `flush`  out  1: zero the IF/ID instruction.
- `md_busy`  out  1: MDU operation in progress.

## Operation
- **Outputs are combinational** from the registered state (`md_state`, `md_cnt`, `lu_q`) and the current inputs.
- **Defaults** when no hazard is active: `pcwrite=1`, `ifidwrite=1`, `idstall=0`, `flush=0`.
- **Priority 1, redirect:** `ex_branch_taken=1` gives `flush=1`, `idstall=1`, `pcwrite=1`, `ifidwrite=1`. Any load-use or MDU stall in the same cycle is suppressed.
- **Priority 2, load-use:** applies when `ex_memread && !lu_q && ex_rt!=0` and either `ex_rt==id_rs` or (`id_use_rt && ex_rt==id_rt`).
  - Outputs: `pcwrite=0`, `ifidwrite=0`, `idstall=1`.
  - `lu_q` is set for the next cycle, during which load-use detection is masked. This gives at most one stall cycle per load.
- **Priority 3, MDU:** applies when `md_busy && id_md_dep`. Outputs: `pcwrite=0`, `ifidwrite=0`, `idstall=1`.
- **MDU state machine:** states MD_IDLE and MD_BUSY.
  - MD_IDLE to MD_BUSY on `md_start && !idstall`. `md_cnt` loads `MUL_CYCLES-1` or `DIV_CYCLES-1` per `md_op`.
  - In MD_BUSY, `md_cnt` decrements each cycle. At `md_cnt==0` the state returns to MD_IDLE.
  - `md_start` is ignored while in MD_BUSY.
- **Redirect during MD_BUSY:** the counter keeps running; an MDU op already issued is not cancelled.
- **`md_busy` output:** equals (`md_state==MD_BUSY`).

## Timing
- **Reset** (`rst_n` low, asynchronous): `md_state=MD_IDLE`, `md_cnt=0`, `lu_q=0`. Outputs then take their combinational values from the inputs; with hazard inputs inactive these are `pcwrite=1`, `ifidwrite=1`, `idstall=0`, `flush=0`, `md_busy=0`.
- **Reset mid-operation** aborts MD_BUSY immediately.
- **Load-use stall and redirect flush:** zero-cycle latency; both take effect in the same cycle as the detecting inputs.
- **MDU occupancy:** an MDU op accepted in cycle T gives `md_busy=1` in cycles T+1 through T+N, where N is the selected latency. `md_busy=0` from T+N+1.
- **Dependent instruction:** an instruction in ID with `id_md_dep` stalls through cycle T+N and proceeds in T+N+1.
- **N=1:** busy for exactly one cycle.

## Configuration
- **Macro `PIPE_HAZARD_MDU_EN` defined:** MDU state machine, counter and stall logic are present as described above.
- **Undefined:** `md_start`, `md_op` and `id_md_dep` are ignored, `md_busy` is tied to 0, and there is no counter or state. Load-use and redirect behaviour is unchanged.

## Structure
- **Package `pipe_ctrl_pkg`:** holds the `md_state_t` enum (MD_IDLE, MD_BUSY), the default `MUL_CYCLES`/`DIV_CYCLES` constants and the `REG_ZERO` constant.
- **Sub-module `md_timer`:**
  - owns the MDU state, the counter and `md_busy`;
  - inputs: `start`, `op`;
  - instantiated only under `PIPE_HAZARD_MDU_EN`.

## Test plan
- **Load-use:** `ex_memread=1`, `ex_rt=5`, `id_rs=5` for 2 cycles. Expect `pcwrite=0`, `ifidwrite=0`, `idstall=1` in cycle 1 only; cycle 2 has defaults (`lu_q` mask).
- **rt false hazard and $0 rule:**
  - `ex_rt=0`, `id_rs=0`: no stall.
  - `id_rt=7`, `id_use_rt=0`, `ex_rt=7`: no stall.
- **Redirect beats load-use:** `ex_branch_taken=1` together with a load-use match. Expect `flush=1`, `idstall=1`, `pcwrite=1`, `ifidwrite=1`.
- **Divide stall:** `md_start=1`, `md_op=1` at T, then `id_md_dep=1`. Expect `md_busy` high T+1..T+16, stall through T+16, release at T+17.
- **Redirect mid-MDU:** `ex_branch_taken=1` at T+3 of a mult. Expect flush at T+3 while `md_busy` stays high until T+4 and falls at T+5.
- **Async reset mid-MDU:** assert `rst_n=0` at T+2 of a divide. Expect `md_busy=0` immediately, no stall after release.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Build option: PIPE_HAZARD_MDU_EN enables multiply/divide occupancy tracking.
package pipe_ctrl_pkg;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    localparam int MUL_CYCLES_DEF = 4;
    localparam int DIV_CYCLES_DEF = 16;
    localparam int CNT_W_DEF      = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode/EX-side hazard inputs and PC/IF-ID control outputs of the hazard controller.
// Build option: PIPE_HAZARD_MDU_EN gives meaning to md_start/md_op/id_md_dep/md_busy.
interface pipe_hazard_ctrl_if;

    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rt;
    logic       ex_memread;
    logic [4:0] ex_rt;
    logic       ex_branch_taken;
    logic       md_start;
    logic       md_op;
    logic       id_md_dep;
    logic       pcwrite;
    logic       ifidwrite;
    logic       idstall;
    logic       flush;
    logic       md_busy;

    modport master (
        output id_rs, id_rt, id_use_rt, ex_memread, ex_rt, ex_branch_taken,
               md_start, md_op, id_md_dep,
        input  pcwrite, ifidwrite, idstall, flush, md_busy
    );

    modport slave (
        input  id_rs, id_rt, id_use_rt, ex_memread, ex_rt, ex_branch_taken,
               md_start, md_op, id_md_dep,
        output pcwrite, ifidwrite, idstall, flush, md_busy
    );

endinterface

// File: rtl/pipe_hazard_ctrl_md_timer.sv
// MDU occupancy timer: tracks a multiply/divide in flight and raises busy for its latency.
// Only built when PIPE_HAZARD_MDU_EN is defined.
`ifdef PIPE_HAZARD_MDU_EN
module md_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic op,
    output logic busy
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    md_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;

    // The counter holds the number of busy cycles still to come after this one,
    // so an N-cycle op loads N-1 and leaves at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (r_state)
                MD_IDLE: begin
                    if (start) begin
                        r_state <= MD_BUSY;
                        r_busy  <= 1'b1;
                        r_cnt   <= op ? DIV_LOAD : MUL_LOAD;
                    end
                end
                MD_BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= MD_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= MD_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;

endmodule
`endif

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: redirect flush, load-use stall and MDU occupancy stall.
// Build option: PIPE_HAZARD_MDU_EN instantiates md_timer; otherwise MDU inputs are ignored.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipe_hazard_ctrl_if.slave    hz
);

    logic r_lu_q;
    logic w_lu_hit;
    logic w_md_busy;
    logic w_md_stall;
    logic w_pcwrite;
    logic w_ifidwrite;
    logic w_idstall;
    logic w_flush;

    // r_lu_q masks detection for the cycle after a hit, bounding a load to one stall.
    assign w_lu_hit = hz.ex_memread && !r_lu_q && (hz.ex_rt != REG_ZERO) &&
                      ((hz.ex_rt == hz.id_rs) ||
                       (hz.id_use_rt && (hz.ex_rt == hz.id_rt)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lu_q <= 1'b0;
        end else begin
            r_lu_q <= w_lu_hit;
        end
    end

`ifdef PIPE_HAZARD_MDU_EN
    logic w_md_start;

    // A bubbled ID instruction must not issue to the MDU.
    assign w_md_start = hz.md_start && !w_idstall;

    md_timer #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_md_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_md_start),
        .op    (hz.md_op),
        .busy  (w_md_busy)
    );

    assign w_md_stall = w_md_busy && hz.id_md_dep;
`else
    logic w_unused;

    assign w_unused   = &{1'b0, hz.md_start, hz.md_op, hz.id_md_dep,
                          MUL_CYCLES[0], DIV_CYCLES[0], CNT_W[0]};
    assign w_md_busy  = 1'b0;
    assign w_md_stall = 1'b0;
`endif

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        w_pcwrite   = 1'b1;
        w_ifidwrite = 1'b1;
        w_idstall   = 1'b0;
        w_flush     = 1'b0;
        if (hz.ex_branch_taken) begin
            w_flush   = 1'b1;
            w_idstall = 1'b1;
        end else if (w_lu_hit || w_md_stall) begin
            w_pcwrite   = 1'b0;
            w_ifidwrite = 1'b0;
            w_idstall   = 1'b1;
        end
    end

    assign hz.pcwrite   = w_pcwrite;
    assign hz.ifidwrite = w_ifidwrite;
    assign hz.idstall   = w_idstall;
    assign hz.flush     = w_flush;
    assign hz.md_busy   = w_md_busy;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios plus random traffic
// against a cycle-level reference model. Honours PIPE_HAZARD_MDU_EN like the design.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_MDU_EN
    localparam bit MDU_EN = 1'b1;
`else
    localparam bit MDU_EN = 1'b0;
`endif
    localparam int MUL_N = 4;
    localparam int DIV_N = 16;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if hz ();

    pipe_hazard_ctrl #(
        .MUL_CYCLES (MUL_N),
        .DIV_CYCLES (DIV_N),
        .CNT_W      (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: busy cycles still ahead, and the one-cycle load-use mask.
    int busy_left = 0;
    bit lu_mask   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic set_idle();
        hz.id_rs           = '0;
        hz.id_rt           = '0;
        hz.id_use_rt       = 1'b0;
        hz.ex_memread      = 1'b0;
        hz.ex_rt           = '0;
        hz.ex_branch_taken = 1'b0;
        hz.md_start        = 1'b0;
        hz.md_op           = 1'b0;
        hz.id_md_dep       = 1'b0;
    endtask

    // Called just after a falling edge with inputs already applied: checks this
    // cycle's outputs against the model, then advances the model across the rising edge.
    task automatic step(input string tag);
        bit lu, md, busy, br, stall;
        #1;
        busy  = MDU_EN && (busy_left > 0);
        lu    = hz.ex_memread && !lu_mask && (hz.ex_rt != 5'd0) &&
                ((hz.ex_rt == hz.id_rs) || (hz.id_use_rt && (hz.ex_rt == hz.id_rt)));
        md    = busy && hz.id_md_dep;
        br    = hz.ex_branch_taken;
        stall = !br && (lu || md);
        check({tag, ".pcwrite"},   32'(hz.pcwrite),   32'(!stall));
        check({tag, ".ifidwrite"}, 32'(hz.ifidwrite), 32'(!stall));
        check({tag, ".idstall"},   32'(hz.idstall),   32'(br || stall));
        check({tag, ".flush"},     32'(hz.flush),     32'(br));
        check({tag, ".md_busy"},   32'(hz.md_busy),   32'(busy));
        @(posedge clk);
        lu_mask = lu;
        if (busy_left > 0)
            busy_left--;
        else if (MDU_EN && hz.md_start && !(br || stall))
            busy_left = hz.md_op ? DIV_N : MUL_N;
        @(negedge clk);
    endtask

    task automatic drain();
        set_idle();
        for (int i = 0; i < 20; i++) step("drain");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_idle();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst.pcwrite",   32'(hz.pcwrite),   32'd1);
        check("rst.ifidwrite", 32'(hz.ifidwrite), 32'd1);
        check("rst.idstall",   32'(hz.idstall),   32'd0);
        check("rst.flush",     32'(hz.flush),     32'd0);
        check("rst.md_busy",   32'(hz.md_busy),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load-use held for two cycles: one stall, then the mask releases it.
        hz.ex_memread = 1'b1; hz.ex_rt = 5'd5; hz.id_rs = 5'd5;
        #1 check("lu_c1.idstall", 32'(hz.idstall), 32'd1);
        step("lu_c1");
        #1 check("lu_c2.idstall", 32'(hz.idstall), 32'd0);
        step("lu_c2");
        set_idle();
        step("lu_gap");

        // $0 destination never stalls; rt match without use_rt never stalls.
        hz.ex_memread = 1'b1; hz.ex_rt = 5'd0; hz.id_rs = 5'd0;
        #1 check("zero.idstall", 32'(hz.idstall), 32'd0);
        step("zero");
        hz.ex_rt = 5'd7; hz.id_rs = 5'd1; hz.id_rt = 5'd7; hz.id_use_rt = 1'b0;
        #1 check("rt_nouse.idstall", 32'(hz.idstall), 32'd0);
        step("rt_nouse");
        hz.id_use_rt = 1'b1;
        #1 check("rt_use.pcwrite", 32'(hz.pcwrite), 32'd0);
        step("rt_use");
        set_idle();
        step("gap");

        // Redirect beats a simultaneous load-use match.
        hz.ex_memread = 1'b1; hz.ex_rt = 5'd9; hz.id_rs = 5'd9; hz.ex_branch_taken = 1'b1;
        #1 check("redir.pcwrite", 32'(hz.pcwrite), 32'd1);
        check("redir.flush", 32'(hz.flush), 32'd1);
        step("redir");
        drain();

        // Divide: busy T+1..T+16, dependent instruction released at T+17.
        hz.md_start = 1'b1; hz.md_op = 1'b1;
        step("div_T");
        hz.md_start = 1'b0; hz.id_md_dep = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            #1 check($sformatf("div_T%0d.md_busy", k), 32'(hz.md_busy), 32'(MDU_EN && k <= 16));
            check($sformatf("div_T%0d.idstall", k), 32'(hz.idstall), 32'(MDU_EN && k <= 16));
            step($sformatf("div_T%0d", k));
        end
        drain();

        // Multiply with a redirect at T+3: busy unaffected, falls at T+5.
        hz.md_start = 1'b1; hz.md_op = 1'b0;
        step("mul_T");
        hz.md_start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            hz.ex_branch_taken = (k == 3);
            #1 check($sformatf("mul_T%0d.md_busy", k), 32'(hz.md_busy), 32'(MDU_EN && k <= 4));
            check($sformatf("mul_T%0d.flush", k), 32'(hz.flush), 32'(k == 3));
            step($sformatf("mul_T%0d", k));
        end
        drain();

        // Asynchronous reset two cycles into a divide.
        hz.md_start = 1'b1; hz.md_op = 1'b1;
        step("rdiv_T");
        hz.md_start = 1'b0;
        step("rdiv_T1");
        rst_n = 1'b0;
        #1 check("rdiv_rst.md_busy", 32'(hz.md_busy), 32'd0);
        busy_left = 0;
        lu_mask   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        hz.id_md_dep = 1'b1;
        #1 check("rdiv_after.idstall", 32'(hz.idstall), 32'd0);
        step("rdiv_after");
        drain();

        // Random traffic; small register range makes operand matches common.
        for (int i = 0; i < 600; i++) begin
            hz.id_rs           = 5'($urandom_range(0, 3));
            hz.id_rt           = 5'($urandom_range(0, 3));
            hz.ex_rt           = 5'($urandom_range(0, 3));
            hz.id_use_rt       = 1'($urandom_range(0, 1));
            hz.ex_memread      = 1'($urandom_range(0, 1));
            hz.ex_branch_taken = ($urandom_range(0, 7) == 0);
            hz.md_start        = ($urandom_range(0, 5) == 0);
            hz.md_op           = 1'($urandom_range(0, 1));
            hz.id_md_dep       = 1'($urandom_range(0, 1));
            step($sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
